// File: rtl/seg7_scan_driver.sv
// Multiplexed DIGITS-wide 7-segment scan driver with frame-synchronous updates,
// leading-zero blanking, 16-step PWM brightness and selectable pin polarity.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0,
    parameter int BLANK_LZ       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic [3:0]            brightness,
    output logic [7:0]            segs,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_tick
);

    localparam int CW   = $clog2(SCAN_DIV);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STEP = SCAN_DIV / 16;

    localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shadow_value;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] active_value;
    logic [DIGITS-1:0]   active_dp;

    logic                boundary;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   dig_sel;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [31:0]         lit_limit;
    logic                seg_on;
    logic                dig_on;
    logic [7:0]          seg_pat;
    logic [DIGITS-1:0]   dig_pat;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign boundary = (idx == IDX_LAST) && (cnt == CNT_LAST);

    // Walk digits from most significant down so the "all higher nibbles zero"
    // condition accumulates in a single pass.
    always_comb begin
        logic        upper_zero;
        int unsigned k;
        upper_zero = 1'b1;
        blank      = '0;
        dig_sel    = '0;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        k          = 0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            k = DIGITS - 1 - j;
            upper_zero = upper_zero && (active_value[4*k +: 4] == 4'h0);
            blank[k]   = (BLANK_LZ != 0) && (k != 0) && upper_zero && !active_dp[k];
            if (idx == IW'(k)) begin
                dig_sel[k] = 1'b1;
                cur_nib    = active_value[4*k +: 4];
                cur_dp     = active_dp[k];
                cur_blank  = blank[k];
            end
        end
    end

    always_comb begin
        lit_limit = (32'(brightness) + 32'd1) * 32'(STEP);
        seg_on    = (32'(cnt) < lit_limit) && !cur_blank;
        dig_on    = seg_on && (cnt != '0);
        seg_pat   = seg_on ? {cur_dp, decode(cur_nib)} : 8'h00;
        dig_pat   = dig_on ? dig_sel : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            active_value <= '0;
            active_dp    <= '0;
            frame_tick   <= 1'b0;
            segs         <= SEG_OFF;
            digit_en     <= DIG_OFF;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp;
            end
            // Active samples the pre-edge shadow, so a coincident load lands a frame later.
            if (boundary) begin
                active_value <= shadow_value;
                active_dp    <= shadow_dp;
            end
            frame_tick <= boundary;
            segs       <= seg_pat ^ SEG_OFF;
            digit_en   <= dig_pat ^ DIG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=16) plus an
// inverted-polarity instance showing a constant digit 8.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic [3:0]  brightness;
    logic [7:0]  segs;
    logic [3:0]  digit_en;
    logic        frame_tick;

    logic [15:0] value_p;
    logic [3:0]  dp_p;
    logic        load_p;
    logic [7:0]  segs_p;
    logic [3:0]  digit_en_p;
    logic        frame_tick_p;

    int n_tests;
    int n_fail;
    int cyc;
    int load_cyc;
    logic [15:0] pend_v;
    logic [3:0]  pend_dp;

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(16), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0), .BLANK_LZ(1)
    ) u_dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
        .brightness(brightness), .segs(segs), .digit_en(digit_en), .frame_tick(frame_tick)
    );

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(16), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLANK_LZ(1)
    ) u_pol (
        .clk(clk), .rst(rst), .value(value_p), .dp(dp_p), .load(load_p),
        .brightness(brightness), .segs(segs_p), .digit_en(digit_en_p), .frame_tick(frame_tick_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        if (cyc + 1 == load_cyc) begin
            load  = 1'b1;
            value = pend_v;
            dp    = pend_dp;
        end else begin
            load = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full 64-cycle frame; es = {d3,d2,d1,d0} segment bytes, bl = blanked digits,
    // thr = (brightness+1) i.e. lit while 1 <= cnt < thr.
    task automatic run_frame(input logic [31:0] es, input logic [3:0] bl, input int thr);
        int lit_n[4];
        int s, i, c;
        logic exp_lit, exp_lit_p;
        for (int d = 0; d < 4; d++) lit_n[d] = 0;
        for (int n = 0; n < 64; n++) begin
            step();
            s = (cyc - 1) % 64;
            i = s / 16;
            c = s % 16;
            exp_lit   = (c != 0) && (c < thr) && !bl[i];
            exp_lit_p = (c != 0) && (c < thr) && (i == 0);
            chk("digit_en", 32'(digit_en), exp_lit ? 32'(4'b0001 << i) : 32'h0);
            if (exp_lit) chk($sformatf("segs_d%0d", i), 32'(segs), 32'(es[i*8 +: 8]));
            else if (c != 0) chk("segs_dark", 32'(segs), 32'h00);
            chk("frame_tick", 32'(frame_tick), (cyc % 64 == 0) ? 32'h1 : 32'h0);
            chk("pol_digit_en", 32'(digit_en_p), exp_lit_p ? 32'hE : 32'hF);
            if (exp_lit_p) chk("pol_segs", 32'(segs_p), (cyc <= 64) ? 32'hC0 : 32'h80);
            else if (c != 0) chk("pol_segs_dark", 32'(segs_p), 32'hFF);
            if (digit_en == (4'b0001 << i)) lit_n[i]++;
        end
        for (int d = 0; d < 4; d++)
            chk($sformatf("lit_count_d%0d", d), 32'(lit_n[d]), bl[d] ? 32'h0 : 32'(thr - 1));
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; load_cyc = -1;
        pend_v = '0; pend_dp = '0;
        rst = 1'b1; value = '0; dp = '0; load = 1'b0; brightness = 4'd15;
        value_p = 16'h0008; dp_p = 4'b0000; load_p = 1'b1;

        step();
        step();
        chk("rst_segs", 32'(segs), 32'h00);
        chk("rst_digit_en", 32'(digit_en), 32'h0);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        chk("rst_pol_segs", 32'(segs_p), 32'hFF);
        chk("rst_pol_digit_en", 32'(digit_en_p), 32'hF);

        rst = 1'b0;
        cyc = 0;
        // Frame 0: zeros shown; load 0x12A7 mid-frame.
        pend_v = 16'h12A7; pend_dp = 4'b0010; load_cyc = 2;
        run_frame(32'h0000003F, 4'b1110, 16);
        // Frame 1: 7, A+dp, 2, 1; queue 0x0005.
        pend_v = 16'h0005; pend_dp = 4'b0000; load_cyc = 100;
        run_frame(32'h065BF707, 4'b0000, 16);
        // Frame 2: brightness 0 gives no visible cycles; queue 0x0005 with dp1.
        brightness = 4'd0;
        pend_v = 16'h0005; pend_dp = 4'b0010; load_cyc = 150;
        run_frame(32'h0000006D, 4'b1110, 1);
        // Frame 3: brightness 7; load on the boundary cycle itself.
        brightness = 4'd7;
        pend_v = 16'h8421; pend_dp = 4'b0000; load_cyc = 256;
        run_frame(32'h0000BF6D, 4'b1100, 8);
        // Frame 4: coincident load not yet visible.
        brightness = 4'd15;
        load_cyc = -1;
        run_frame(32'h0000BF6D, 4'b1100, 16);
        // Frame 5: 1, 2, 4, 8.
        run_frame(32'h7F665B06, 4'b0000, 16);

        for (int n = 0; n < 21; n++) step();
        rst = 1'b1;
        step();
        chk("midrst_segs", 32'(segs), 32'h00);
        chk("midrst_digit_en", 32'(digit_en), 32'h0);
        chk("midrst_frame_tick", 32'(frame_tick), 32'h0);
        chk("midrst_pol_segs", 32'(segs_p), 32'hFF);
        chk("midrst_pol_digit_en", 32'(digit_en_p), 32'hF);
        rst = 1'b0;
        cyc = 0;
        run_frame(32'h0000003F, 4'b1110, 16);
        run_frame(32'h0000003F, 4'b1110, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
